// File: rtl/oam_scan_if.sv
// Bus bundle between the OAM sprite search stage, the OAM memory and the pixel fetcher.
// Clock and reset stay as plain ports on the module that uses this bundle.
interface oam_scan_if;
    logic [7:0] v;
    logic       scan_start;
    logic       obj_size;
    logic [5:0] oam_idx;
    logic [7:0] oam_y;
    logic [7:0] oam_x;
    logic       scanning;
    logic       scan_done;
    logic [3:0] spr_count;
    logic [3:0] spr_sel;
    logic [5:0] spr_idx;
    logic [7:0] spr_x;
    logic [3:0] spr_row;

    modport master (
        output v, scan_start, obj_size, oam_y, oam_x, spr_sel,
        input  oam_idx, scanning, scan_done, spr_count, spr_idx, spr_x, spr_row
    );

    modport slave (
        input  v, scan_start, obj_size, oam_y, oam_x, spr_sel,
        output oam_idx, scanning, scan_done, spr_count, spr_idx, spr_x, spr_row
    );
endinterface

// File: rtl/oam_scan.sv
// Per-line OAM search: walks 40 entries at two clocks each and keeps up to 10
// sprites whose vertical span covers the latched line, for the pixel fetcher to read.
module oam_scan (
    input  logic       clk2,
    input  logic       nreset_video,
    oam_scan_if.slave  bus
);

    localparam logic [5:0] LAST_IDX = 6'd39;
    localparam logic [3:0] MAX_SPR  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_scanning;
    logic       r_done;
    logic       r_phase;
    logic [5:0] r_idx;
    logic [7:0] r_line;
    logic       r_size;
    logic [3:0] r_count;

    logic [5:0] r_slot_idx [0:9];
    logic [7:0] r_slot_x   [0:9];
    logic [3:0] r_slot_row [0:9];

    logic       w_last;
    logic       w_hit;
    logic       w_store;
    logic [3:0] w_row;
    logic       w_sel_valid;
    logic [5:0] w_rd_idx;
    logic [7:0] w_rd_x;
    logic [3:0] w_rd_row;

    // Sprite covers line L = line + 16 when y <= L < y + height (9-bit to avoid wrap).
    function automatic logic sprite_hit(input logic [7:0] line, input logic size,
                                        input logic [7:0] y);
        logic [8:0] l9;
        logic [8:0] y9;
        logic [8:0] h9;
        l9 = {1'b0, line} + 9'd16;
        y9 = {1'b0, y};
        h9 = size ? 9'd16 : 9'd8;
        return (y9 <= l9) && (l9 < (y9 + h9));
    endfunction

    // (line + 16 - y) mod 16 only depends on the low nibbles.
    function automatic logic [3:0] sprite_row(input logic [7:0] line, input logic [7:0] y);
        return line[3:0] - y[3:0];
    endfunction

    assign w_last      = r_phase && (r_idx == LAST_IDX);
    assign w_hit       = sprite_hit(r_line, r_size, bus.oam_y);
    assign w_row       = sprite_row(r_line, bus.oam_y);
    assign w_store     = (r_state == ST_SCAN) && r_phase && w_hit &&
                         (r_count < MAX_SPR) && !bus.scan_start;
    assign w_sel_valid = (bus.spr_sel < r_count);

    // Next-state decode; a start pulse always (re)enters SCAN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.scan_start) begin
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (bus.scan_start) begin
                    w_state_nxt = ST_SCAN;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_DONE: begin
                if (bus.scan_start) begin
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register with status flags registered alongside it.
    always_ff @(posedge clk2 or negedge nreset_video) begin
        if (!nreset_video) begin
            r_state    <= ST_IDLE;
            r_scanning <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_scanning <= (w_state_nxt == ST_SCAN);
            r_done     <= (w_state_nxt == ST_DONE);
        end
    end

    // Scan sequencing: latched line/size, entry address, phase and hit count.
    always_ff @(posedge clk2 or negedge nreset_video) begin
        if (!nreset_video) begin
            r_line  <= 8'd0;
            r_size  <= 1'b0;
            r_idx   <= 6'd0;
            r_phase <= 1'b0;
            r_count <= 4'd0;
        end else if (bus.scan_start) begin
            r_line  <= bus.v;
            r_size  <= bus.obj_size;
            r_idx   <= 6'd0;
            r_phase <= 1'b0;
            r_count <= 4'd0;
        end else if (r_state == ST_SCAN) begin
            if (r_phase) begin
                r_phase <= 1'b0;
                if (!w_last) begin
                    r_idx <= r_idx + 6'd1;
                end else begin
                    r_idx <= r_idx;
                end
                if (w_store) begin
                    r_count <= r_count + 4'd1;
                end else begin
                    r_count <= r_count;
                end
            end else begin
                r_phase <= 1'b1;
            end
        end else begin
            r_phase <= r_phase;
        end
    end

    // Sprite store: a hit lands in the slot numbered by the current count.
    always_ff @(posedge clk2 or negedge nreset_video) begin
        if (!nreset_video) begin
            for (int i = 0; i < 10; i++) begin
                r_slot_idx[i] <= 6'd0;
                r_slot_x[i]   <= 8'd0;
                r_slot_row[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (w_store && (r_count == 4'(i))) begin
                    r_slot_idx[i] <= r_idx;
                    r_slot_x[i]   <= bus.oam_x;
                    r_slot_row[i] <= w_row;
                end else begin
                    r_slot_idx[i] <= r_slot_idx[i];
                    r_slot_x[i]   <= r_slot_x[i];
                    r_slot_row[i] <= r_slot_row[i];
                end
            end
        end
    end

    // Store read port; slots at or beyond the count read as zero so stale data stays hidden.
    always_comb begin
        w_rd_idx = 6'd0;
        w_rd_x   = 8'd0;
        w_rd_row = 4'd0;
        if (w_sel_valid) begin
            w_rd_idx = r_slot_idx[bus.spr_sel];
            w_rd_x   = r_slot_x[bus.spr_sel];
            w_rd_row = r_slot_row[bus.spr_sel];
        end else begin
            w_rd_idx = 6'd0;
            w_rd_x   = 8'd0;
            w_rd_row = 4'd0;
        end
    end

    assign bus.oam_idx   = r_idx;
    assign bus.scanning  = r_scanning;
    assign bus.scan_done = r_done;
    assign bus.spr_count = r_count;
    assign bus.spr_idx   = w_rd_idx;
    assign bus.spr_x     = w_rd_x;
    assign bus.spr_row   = w_rd_row;

endmodule

// File: tb/tb_oam_scan.sv
// Directed bench for oam_scan: behavioural OAM memory with one-cycle read latency,
// hand-computed expectations checked inline per scenario.
`timescale 1ns/1ps
module tb_oam_scan;
    logic clk2 = 1'b0;
    logic nreset_video = 1'b0;
    oam_scan_if bus ();

    oam_scan dut (
        .clk2         (clk2),
        .nreset_video (nreset_video),
        .bus          (bus)
    );

    always #5 clk2 = ~clk2;

    logic [7:0] mem_y [0:39];
    logic [7:0] mem_x [0:39];
    int  n_checks  = 0;
    int  n_fail    = 0;
    int  cur_cycle = 0;
    bit  wiggle_en = 1'b0;

    // OAM memory: data for the address seen at an edge is valid in the following cycle.
    always @(posedge clk2) begin
        bus.oam_y <= mem_y[bus.oam_idx];
        bus.oam_x <= mem_x[bus.oam_idx];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mem();
        for (int i = 0; i < 40; i++) begin
            mem_y[i] = 8'd0;
            mem_x[i] = 8'd0;
        end
    endtask

    // Pulse scan_start across one edge; afterwards we sit mid-cycle of the next cycle.
    task automatic pulse_start();
        bus.scan_start = 1'b1;
        @(posedge clk2);
        #1 bus.scan_start = 1'b0;
        @(negedge clk2);
        cur_cycle = cur_cycle + 1;
    endtask

    task automatic goto_cycle(input int c);
        bit moved;
        moved = 1'b0;
        while (cur_cycle < c) begin
            @(posedge clk2);
            #1;
            if (wiggle_en) begin
                bus.v        = 8'($urandom);
                bus.obj_size = ~bus.obj_size;
            end
            cur_cycle = cur_cycle + 1;
            moved = 1'b1;
        end
        if (moved) @(negedge clk2);
    endtask

    task automatic set_boundary_mem();
        clear_mem();
        for (int i = 0; i < 40; i++) mem_x[i] = 8'(i * 10 + 1);
        mem_y[2] = 8'd16;
        mem_y[3] = 8'd15;
        mem_y[4] = 8'd8;
        mem_y[5] = 8'd24;
        mem_y[6] = 8'd23;
    endtask

    task automatic test_reset();
        logic [11:0] st;
        bus.v = 8'd0; bus.scan_start = 1'b0; bus.obj_size = 1'b0; bus.spr_sel = 4'd0;
        clear_mem();
        #3;
        st = {bus.scanning, bus.scan_done, bus.spr_count, bus.oam_idx};
        n_checks++; if (st !== 12'd0) begin n_fail++; $display("FAIL reset_initial: got %h expected 000", st); end
        #9 nreset_video = 1'b1;
        @(negedge clk2);
        mem_y[0] = 8'd16;
        cur_cycle = 0;
        pulse_start();
        goto_cycle(20);
        n_checks++; if ({bus.scanning, bus.spr_count} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL reset_prescan: got %b expected 10001", {bus.scanning, bus.spr_count}); end
        nreset_video = 1'b0;
        #1;
        st = {bus.scanning, bus.scan_done, bus.spr_count, bus.oam_idx};
        n_checks++; if (st !== 12'd0) begin n_fail++; $display("FAIL reset_async: got %h expected 000", st); end
        n_checks++; if ({bus.spr_idx, bus.spr_x, bus.spr_row} !== 18'd0) begin n_fail++; $display("FAIL reset_slot0: got %h expected 0", {bus.spr_idx, bus.spr_x, bus.spr_row}); end
        #1 nreset_video = 1'b1;
        repeat (10) @(posedge clk2);
        @(negedge clk2);
        st = {bus.scanning, bus.scan_done, bus.spr_count, bus.oam_idx};
        n_checks++; if (st !== 12'd0) begin n_fail++; $display("FAIL reset_stays_idle: got %h expected 000", st); end
    endtask

    task automatic test_basic_hit();
        clear_mem();
        mem_y[5] = 8'd16; mem_x[5] = 8'd40;
        bus.v = 8'd0; bus.obj_size = 1'b0; bus.spr_sel = 4'd0;
        cur_cycle = 0;
        pulse_start();
        n_checks++; if ({bus.scanning, bus.scan_done, bus.oam_idx} !== {1'b1, 1'b0, 6'd0}) begin n_fail++; $display("FAIL basic_cycle1: got %b expected 10000000", {bus.scanning, bus.scan_done, bus.oam_idx}); end
        goto_cycle(3);
        n_checks++; if (bus.oam_idx !== 6'd1) begin n_fail++; $display("FAIL basic_idx_c3: got %0d expected 1", bus.oam_idx); end
        goto_cycle(12);
        n_checks++; if (bus.spr_count !== 4'd0) begin n_fail++; $display("FAIL basic_count_c12: got %0d expected 0", bus.spr_count); end
        goto_cycle(13);
        n_checks++; if (bus.spr_count !== 4'd1) begin n_fail++; $display("FAIL basic_count_c13: got %0d expected 1", bus.spr_count); end
        goto_cycle(80);
        n_checks++; if ({bus.scanning, bus.scan_done, bus.oam_idx} !== {1'b1, 1'b0, 6'd39}) begin n_fail++; $display("FAIL basic_cycle80: got %b expected 10100111", {bus.scanning, bus.scan_done, bus.oam_idx}); end
        goto_cycle(81);
        n_checks++; if ({bus.scanning, bus.scan_done, bus.spr_count} !== {1'b0, 1'b1, 4'd1}) begin n_fail++; $display("FAIL basic_cycle81: got %b expected 010001", {bus.scanning, bus.scan_done, bus.spr_count}); end
        n_checks++; if ({bus.spr_idx, bus.spr_x, bus.spr_row} !== {6'd5, 8'd40, 4'd0}) begin n_fail++; $display("FAIL basic_slot0: got %h expected %h", {bus.spr_idx, bus.spr_x, bus.spr_row}, {6'd5, 8'd40, 4'd0}); end
        bus.spr_sel = 4'd1; #1;
        n_checks++; if ({bus.spr_idx, bus.spr_x, bus.spr_row} !== 18'd0) begin n_fail++; $display("FAIL basic_slot1_zero: got %h expected 0", {bus.spr_idx, bus.spr_x, bus.spr_row}); end
        bus.spr_sel = 4'd0;
        goto_cycle(95);
        n_checks++; if ({bus.scan_done, bus.oam_idx, bus.spr_count} !== {1'b1, 6'd39, 4'd1}) begin n_fail++; $display("FAIL basic_done_hold: got %b expected 11001110001", {bus.scan_done, bus.oam_idx, bus.spr_count}); end
    endtask

    task automatic test_boundary();
        logic [17:0] exp1 [0:3];
        logic [17:0] exp0 [0:1];
        exp1[0] = {6'd2, 8'd21, 4'd7};
        exp1[1] = {6'd3, 8'd31, 4'd8};
        exp1[2] = {6'd4, 8'd41, 4'd15};
        exp1[3] = {6'd6, 8'd61, 4'd0};
        exp0[0] = {6'd2, 8'd21, 4'd7};
        exp0[1] = {6'd6, 8'd61, 4'd0};
        set_boundary_mem();
        bus.v = 8'd7; bus.obj_size = 1'b1;
        cur_cycle = 0;
        pulse_start();
        n_checks++; if ({bus.scan_done, bus.spr_count} !== {1'b0, 4'd0}) begin n_fail++; $display("FAIL bnd_restart_from_done: got %b expected 00000", {bus.scan_done, bus.spr_count}); end
        goto_cycle(81);
        n_checks++; if (bus.spr_count !== 4'd4) begin n_fail++; $display("FAIL bnd16_count: got %0d expected 4", bus.spr_count); end
        for (int i = 0; i < 4; i++) begin
            bus.spr_sel = 4'(i); #1;
            n_checks++; if ({bus.spr_idx, bus.spr_x, bus.spr_row} !== exp1[i]) begin n_fail++; $display("FAIL bnd16_slot%0d: got %h expected %h", i, {bus.spr_idx, bus.spr_x, bus.spr_row}, exp1[i]); end
        end
        bus.spr_sel = 4'd0;
        bus.obj_size = 1'b0;
        @(negedge clk2);
        cur_cycle = 0;
        pulse_start();
        goto_cycle(81);
        n_checks++; if (bus.spr_count !== 4'd2) begin n_fail++; $display("FAIL bnd8_count: got %0d expected 2", bus.spr_count); end
        for (int i = 0; i < 2; i++) begin
            bus.spr_sel = 4'(i); #1;
            n_checks++; if ({bus.spr_idx, bus.spr_x, bus.spr_row} !== exp0[i]) begin n_fail++; $display("FAIL bnd8_slot%0d: got %h expected %h", i, {bus.spr_idx, bus.spr_x, bus.spr_row}, exp0[i]); end
        end
        bus.spr_sel = 4'd2; #1;
        n_checks++; if ({bus.spr_idx, bus.spr_x, bus.spr_row} !== 18'd0) begin n_fail++; $display("FAIL bnd8_stale_hidden: got %h expected 0", {bus.spr_idx, bus.spr_x, bus.spr_row}); end
        bus.spr_sel = 4'd0;
        @(negedge clk2);
    endtask

    task automatic test_overflow();
        logic [17:0] exp;
        clear_mem();
        for (int i = 0; i < 40; i++) begin
            mem_y[i] = 8'd16;
            mem_x[i] = (i == 9) ? 8'd200 : 8'(i * 3);
        end
        bus.v = 8'd0; bus.obj_size = 1'b0;
        cur_cycle = 0;
        pulse_start();
        goto_cycle(20);
        n_checks++; if (bus.spr_count !== 4'd9) begin n_fail++; $display("FAIL ovf_count_c20: got %0d expected 9", bus.spr_count); end
        goto_cycle(21);
        n_checks++; if (bus.spr_count !== 4'd10) begin n_fail++; $display("FAIL ovf_count_c21: got %0d expected 10", bus.spr_count); end
        goto_cycle(81);
        n_checks++; if ({bus.scan_done, bus.spr_count} !== {1'b1, 4'd10}) begin n_fail++; $display("FAIL ovf_final: got %b expected 11010", {bus.scan_done, bus.spr_count}); end
        for (int i = 0; i < 10; i++) begin
            bus.spr_sel = 4'(i); #0.2;
            exp = {6'(i), ((i == 9) ? 8'd200 : 8'(i * 3)), 4'd0};
            n_checks++; if ({bus.spr_idx, bus.spr_x, bus.spr_row} !== exp) begin n_fail++; $display("FAIL ovf_slot%0d: got %h expected %h", i, {bus.spr_idx, bus.spr_x, bus.spr_row}, exp); end
        end
        bus.spr_sel = 4'd10; #0.2;
        n_checks++; if ({bus.spr_idx, bus.spr_x, bus.spr_row} !== 18'd0) begin n_fail++; $display("FAIL ovf_sel10_zero: got %h expected 0", {bus.spr_idx, bus.spr_x, bus.spr_row}); end
        bus.spr_sel = 4'd15; #0.2;
        n_checks++; if ({bus.spr_idx, bus.spr_x, bus.spr_row} !== 18'd0) begin n_fail++; $display("FAIL ovf_sel15_zero: got %h expected 0", {bus.spr_idx, bus.spr_x, bus.spr_row}); end
        bus.spr_sel = 4'd0;
        @(negedge clk2);
    endtask

    task automatic test_restart();
        clear_mem();
        mem_y[1]  = 8'd16; mem_x[1]  = 8'd7;
        mem_y[4]  = 8'd16; mem_x[4]  = 8'd28;
        mem_y[8]  = 8'd16; mem_x[8]  = 8'd56;
        mem_y[14] = 8'd16; mem_x[14] = 8'd98;
        bus.v = 8'd0; bus.obj_size = 1'b0;
        cur_cycle = 0;
        pulse_start();
        goto_cycle(30);
        n_checks++; if ({bus.spr_count, bus.oam_idx} !== {4'd3, 6'd14}) begin n_fail++; $display("FAIL rst_before: got count %0d idx %0d expected 3 14", bus.spr_count, bus.oam_idx); end
        pulse_start();
        n_checks++; if ({bus.scanning, bus.scan_done, bus.oam_idx, bus.spr_count} !== {1'b1, 1'b0, 6'd0, 4'd0}) begin n_fail++; $display("FAIL rst_after: got %b expected 100000000000", {bus.scanning, bus.scan_done, bus.oam_idx, bus.spr_count}); end
        goto_cycle(110);
        n_checks++; if ({bus.scanning, bus.scan_done} !== 2'b10) begin n_fail++; $display("FAIL rst_still_scanning: got %b expected 10", {bus.scanning, bus.scan_done}); end
        goto_cycle(111);
        n_checks++; if ({bus.scan_done, bus.spr_count} !== {1'b1, 4'd4}) begin n_fail++; $display("FAIL rst_done: got %b expected 10100", {bus.scan_done, bus.spr_count}); end
        bus.spr_sel = 4'd3; #1;
        n_checks++; if ({bus.spr_idx, bus.spr_x, bus.spr_row} !== {6'd14, 8'd98, 4'd0}) begin n_fail++; $display("FAIL rst_slot3: got %h expected %h", {bus.spr_idx, bus.spr_x, bus.spr_row}, {6'd14, 8'd98, 4'd0}); end
        bus.spr_sel = 4'd0;
        @(negedge clk2);
    endtask

    task automatic test_wrap();
        clear_mem();
        mem_y[0] = 8'd255; mem_x[0] = 8'd9;
        mem_y[1] = 8'd251; mem_x[1] = 8'd8;
        mem_y[2] = 8'd250; mem_x[2] = 8'd7;
        bus.v = 8'd250; bus.obj_size = 1'b1;
        cur_cycle = 0;
        pulse_start();
        goto_cycle(81);
        n_checks++; if (bus.spr_count !== 4'd2) begin n_fail++; $display("FAIL wrap_count: got %0d expected 2", bus.spr_count); end
        bus.spr_sel = 4'd0; #1;
        n_checks++; if ({bus.spr_idx, bus.spr_x, bus.spr_row} !== {6'd0, 8'd9, 4'd11}) begin n_fail++; $display("FAIL wrap_slot0: got %h expected %h", {bus.spr_idx, bus.spr_x, bus.spr_row}, {6'd0, 8'd9, 4'd11}); end
        bus.spr_sel = 4'd1; #1;
        n_checks++; if ({bus.spr_idx, bus.spr_x, bus.spr_row} !== {6'd1, 8'd8, 4'd15}) begin n_fail++; $display("FAIL wrap_slot1: got %h expected %h", {bus.spr_idx, bus.spr_x, bus.spr_row}, {6'd1, 8'd8, 4'd15}); end
        bus.spr_sel = 4'd0;
        @(negedge clk2);
    endtask

    task automatic test_latch();
        logic [17:0] exp1 [0:3];
        exp1[0] = {6'd2, 8'd21, 4'd7};
        exp1[1] = {6'd3, 8'd31, 4'd8};
        exp1[2] = {6'd4, 8'd41, 4'd15};
        exp1[3] = {6'd6, 8'd61, 4'd0};
        set_boundary_mem();
        bus.v = 8'd7; bus.obj_size = 1'b1;
        cur_cycle = 0;
        pulse_start();
        wiggle_en = 1'b1;
        goto_cycle(81);
        wiggle_en = 1'b0;
        n_checks++; if ({bus.scan_done, bus.spr_count} !== {1'b1, 4'd4}) begin n_fail++; $display("FAIL latch_count: got %b expected 10100", {bus.scan_done, bus.spr_count}); end
        for (int i = 0; i < 4; i++) begin
            bus.spr_sel = 4'(i); #1;
            n_checks++; if ({bus.spr_idx, bus.spr_x, bus.spr_row} !== exp1[i]) begin n_fail++; $display("FAIL latch_slot%0d: got %h expected %h", i, {bus.spr_idx, bus.spr_x, bus.spr_row}, exp1[i]); end
        end
        bus.spr_sel = 4'd0;
        @(negedge clk2);
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_boundary();
        test_overflow();
        test_restart();
        test_wrap();
        test_latch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
